ram_bist: RTL and testbench

- Synchronous built-in self-test initiator for the 16x8 asynchronous single-port RAM.
- Drives that RAM's `addr`/`we`/`enable` pins and its shared bidirectional data bus.
- Runs a two-pass write/read-compare march and reports pass/fail with first-failure capture.
- Sits between the lab top level (start/status) and the RAM instance; it is the only bus master on the RAM port.

---
 rtl/ram_bist_pkg.sv | 7 +
 rtl/ram_bist_pattern.sv | 14 +
 rtl/ram_bist.sv | 131 +++++++++++++
 tb/tb_ram_bist.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: state encoding and shared widths for the RAM march BIST.
package ram_bist_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_WR_SETUP, S_WR_PULSE, S_TURN, S_RD_SETUP, S_RD_SAMPLE, S_DONE
    } state_t;
    localparam int ERR_CNT_W = 5;
endpackage

// File: rtl/ram_bist_pattern.sv
// ram_bist_pattern: expected march data for an address and pass index.
module ram_bist_pattern #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_pass_idx,
    output logic [DATA_W-1:0] o_exp
);
    logic [DATA_W-1:0] w_base;
    assign w_base = PATTERN ^ DATA_W'({2{i_addr}});
    assign o_exp  = i_pass_idx ? ~w_base : w_base;
endmodule

// File: rtl/ram_bist.sv
// ram_bist: two-pass write/read-compare march over an async single-port RAM,
// with saturating error count and first-failure capture.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hA5,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    inout  wire  [DATA_W-1:0]    ram_data,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_we,
    output logic                 ram_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_data,
    output logic                 fail_pass
);
    state_t            r_state;
    logic              r_pass_idx;
    logic              r_drive;
    logic              r_turn_to_wr;
    logic [DATA_W-1:0] w_exp;
    logic              w_max;
    logic              w_mis;
    logic [ERR_CNT_W-1:0] w_err_inc;

    ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(PATTERN)) u_pattern (
        .i_addr    (ram_addr),
        .i_pass_idx(r_pass_idx),
        .o_exp     (w_exp)
    );

    assign ram_data  = r_drive ? w_exp : {DATA_W{1'bz}};
    assign w_max     = &ram_addr;
    assign w_mis     = ram_data !== w_exp;
    assign w_err_inc = (&err_count) ? err_count : err_count + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pass_idx   <= 1'b0;
            r_drive      <= 1'b0;
            r_turn_to_wr <= 1'b0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_addr    <= '0;
            fail_data    <= '0;
            fail_pass    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_state    <= S_WR_SETUP;
                    ram_addr   <= '0;
                    r_pass_idx <= 1'b0;
                    r_drive    <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                    err_count  <= '0;
                    fail_addr  <= '0;
                    fail_data  <= '0;
                    fail_pass  <= 1'b0;
                end
                S_WR_SETUP: begin
                    r_state <= S_WR_PULSE;
                    ram_we  <= 1'b1;
                end
                S_WR_PULSE: begin
                    ram_we <= 1'b0;
                    if (!w_max) begin
                        r_state  <= S_WR_SETUP;
                        ram_addr <= ram_addr + 1'b1;
                    end else begin
                        r_state      <= S_TURN;
                        ram_addr     <= '0;
                        r_drive      <= 1'b0;
                        r_turn_to_wr <= 1'b0;
                    end
                end
                S_TURN: if (r_turn_to_wr) begin
                    r_state    <= S_WR_SETUP;
                    r_pass_idx <= 1'b1;
                    r_drive    <= 1'b1;
                end else begin
                    r_state    <= S_RD_SETUP;
                    ram_enable <= 1'b1;
                end
                S_RD_SETUP: r_state <= S_RD_SAMPLE;
                S_RD_SAMPLE: begin
                    if (w_mis) begin
                        err_count <= w_err_inc;
                        if (err_count == '0) begin
                            fail_addr <= ram_addr;
                            fail_data <= ram_data;
                            fail_pass <= r_pass_idx;
                        end
                    end
                    if ((w_mis && STOP_ON_FAIL) || (w_max && r_pass_idx)) begin
                        r_state    <= S_DONE;
                        ram_enable <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (err_count == '0) && !w_mis;
                    end else if (!w_max) begin
                        r_state  <= S_RD_SETUP;
                        ram_addr <= ram_addr + 1'b1;
                    end else begin
                        r_state      <= S_TURN;
                        ram_enable   <= 1'b0;
                        ram_addr     <= '0;
                        r_turn_to_wr <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: two BIST instances (stop-on-fail and run-to-end) against RAM models with injectable read faults.
module tb_ram_bist;
    typedef struct packed {
        logic pass;
        int   err;
        int   fa;
        int   fd;
        int   fp;
        int   lat;
        int   t0;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   f_kind = 0;
    int   f_addr = 0;
    int   f_bit = 0;
    logic f_val = 1'b0;
    res_t q0[$];
    res_t q1[$];

    wire  [7:0] bus0, bus1;
    logic [3:0] addr0, addr1, fa0, fa1, pa0, pa1;
    logic       we0, we1, en0, en1, busy0, busy1, done0, done1, pass0, pass1, fp0, fp1, pd0, pd1;
    logic [4:0] err0, err1;
    logic [7:0] fd0, fd1;
    logic [7:0] m0 [16];
    logic [7:0] m1 [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_bist #(.STOP_ON_FAIL(1'b1)) u0 (
        .clock(clk), .reset(reset), .start(start), .ram_data(bus0), .ram_addr(addr0),
        .ram_we(we0), .ram_enable(en0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_addr(fa0), .fail_data(fd0), .fail_pass(fp0)
    );
    ram_bist #(.STOP_ON_FAIL(1'b0)) u1 (
        .clock(clk), .reset(reset), .start(start), .ram_data(bus1), .ram_addr(addr1),
        .ram_we(we1), .ram_enable(en1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_addr(fa1), .fail_data(fd1), .fail_pass(fp1)
    );

    function automatic logic [7:0] expv(int p, int a);
        logic [3:0] n = a[3:0];
        logic [7:0] v = 8'hA5 ^ {n, n};
        return p != 0 ? ~v : v;
    endfunction

    // What the faulty RAM returns on a read of stored value v at address a.
    function automatic logic [7:0] faulty(logic [7:0] v, int a);
        logic [7:0] r = v;
        if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
        if (f_kind == 2) r = ~v;
        return r;
    endfunction

    always @(posedge clk) begin
        if (we0 && !en0) m0[addr0] <= bus0;
        if (we1 && !en1) m1[addr1] <= bus1;
    end
    assign bus0 = (en0 && !we0) ? faulty(m0[addr0], int'(addr0)) : 8'bz;
    assign bus1 = (en1 && !we1) ? faulty(m1[addr1], int'(addr1)) : 8'bz;

    // Reference: walk both passes over the march, reading back through the fault model.
    function automatic res_t model(bit stop, int t0);
        res_t r;
        r = '{pass: 1'b0, err: 0, fa: 0, fd: 0, fp: 0, lat: 131, t0: t0};
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 16; a++) begin
                logic [7:0] e = expv(p, a);
                logic [7:0] rd = faulty(e, a);
                if (rd != e) begin
                    if (r.err == 0) begin
                        r.fa = a;
                        r.fd = int'(rd);
                        r.fp = p;
                    end
                    r.err++;
                    if (stop) begin
                        r.lat = 66 * p + 35 + 2 * a;
                        return r;
                    end
                end
            end
        if (r.err > 31) r.err = 31;
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_done(string tag, res_t e, logic p, logic [4:0] er, logic [3:0] fa,
                            logic [7:0] fd, logic fp, logic bz);
        chk({tag, "_pass"}, int'(p), int'(e.pass));
        chk({tag, "_err"}, int'(er), e.err);
        chk({tag, "_fail_addr"}, int'(fa), e.fa);
        chk({tag, "_fail_data"}, int'(fd), e.fd);
        chk({tag, "_fail_pass"}, int'(fp), e.fp);
        chk({tag, "_busy"}, int'(bz), 0);
        chk({tag, "_latency"}, cyc - e.t0, e.lat);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("d0_we_and_en", int'(we0 && en0), 0);
            chk("d0_bus_while_en", int'(u0.r_drive && en0), 0);
            if (we0) chk("d0_addr_hold", int'(addr0), int'(pa0));
        end
        if (done0 && !pd0) begin
            if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
            else chk_done("d0", q0.pop_front(), pass0, err0, fa0, fd0, fp0, busy0);
        end
        pd0 = done0;
        pa0 = addr0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("d1_we_and_en", int'(we1 && en1), 0);
            chk("d1_bus_while_en", int'(u1.r_drive && en1), 0);
            if (we1) chk("d1_addr_hold", int'(addr1), int'(pa1));
        end
        if (done1 && !pd1) begin
            if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
            else chk_done("d1", q1.pop_front(), pass1, err1, fa1, fd1, fp1, busy1);
        end
        pd1 = done1;
        pa1 = addr1;
    end

    task automatic chk_reset();
        chk("rst_we", int'({we0, we1}), 0);
        chk("rst_en", int'({en0, en1}), 0);
        chk("rst_addr0", int'(addr0), 0);
        chk("rst_addr1", int'(addr1), 0);
        chk("rst_busy", int'({busy0, busy1}), 0);
        chk("rst_done", int'({done0, done1}), 0);
        chk("rst_pass", int'({pass0, pass1}), 0);
        chk("rst_err", int'({err0, err1}), 0);
        chk("rst_fail_addr", int'({fa0, fa1}), 0);
        chk("rst_fail_data", int'({fd0, fd1}), 0);
        chk("rst_fail_pass", int'({fp0, fp1}), 0);
        chk("rst_bus_drive", int'({u0.r_drive, u1.r_drive}), 0);
    endtask

    task automatic launch(int kind, int fa, int fb, logic fv);
        f_kind = kind;
        f_addr = fa;
        f_bit  = fb;
        f_val  = fv;
        q0.push_back(model(1'b1, cyc + 1));
        q1.push_back(model(1'b0, cyc + 1));
        start = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        chk("done_timeout", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    task automatic run(int kind, int fa, int fb, logic fv);
        launch(kind, fa, fb, fv);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset();
        reset = 1'b0;
        @(negedge clk);
        run(0, 0, 0, 1'b0);
        chk("mem0_addr3", int'(m0[3]), 8'h69);
        chk("mem1_addr3", int'(m1[3]), 8'h69);
        run(1, 5, 0, 1'b1);
        run(2, 0, 0, 1'b0);
        for (int k = 0; k < 5; k++)
            run(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)), 1'($urandom));
        // Abort mid pass-0 read phase, then a clean rerun.
        f_kind = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset();
        reset = 1'b0;
        @(negedge clk);
        run(0, 0, 0, 1'b0);
        // Start held, then a second pulse near N+10: neither may restart the run.
        launch(0, 0, 0, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        launch(0, 0, 0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", int'({done0, done1}), 0);
        chk("restart_busy", int'({busy0, busy1}), 3);
        wait_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
